// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: request/response bundle between the microsequencer and the HI/LO mul/div unit.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
    logic             start_mul, start_div;
    logic [WIDTH-1:0] rs_val, rt_val;
    logic [1:0]       hiSel, loSel;
    logic             hiWr, loWr, mALUOp;
    logic             busy, done, hazard, div_by_zero;
    logic [WIDTH-1:0] hi, lo;
    modport master (
        output start_mul, start_div, rs_val, rt_val, hiSel, loSel, hiWr, loWr, mALUOp,
        input  busy, done, hazard, div_by_zero, hi, lo
    );
    modport slave (
        input  start_mul, start_div, rs_val, rt_val, hiSel, loSel, hiWr, loWr, mALUOp,
        output busy, done, hazard, div_by_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO registers with 1-cycle signed multiply, 32-step signed restoring divide and madd/msub.
// Define DIV_ZERO_TRAP_EN to finish a zero-divisor divide in one cycle and raise div_by_zero.
module hilo_muldiv_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
    input logic        clk,
    input logic        rst,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t             state_q;
    logic [2*WIDTH-1:0] res_q, mac_d, prod;
    logic [WIDTH-1:0]   hi_q, lo_q, a_q, b_q, rem_q, hi_d, lo_d, quo_fix, rem_fix;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic [CW-1:0]      cnt_q;
    logic               sa_q, sb_q, busy_q, done_q, hazard_q;
    logic               hi_blk, lo_blk, hi_we, lo_we;
`ifdef DIV_ZERO_TRAP_EN
    logic               dz_q, dbz_q;
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif
    always_comb begin
        mac_d   = bus.mALUOp ? {hi_q, lo_q} - res_q : {hi_q, lo_q} + res_q;
        hi_d    = bus.hiSel == 2'b00 ? res_q[2*WIDTH-1:WIDTH] : bus.hiSel == 2'b01 ? bus.rs_val :
                  bus.hiSel == 2'b10 ? mac_d[2*WIDTH-1:WIDTH] : hi_q;
        lo_d    = bus.loSel == 2'b00 ? res_q[WIDTH-1:0] : bus.loSel == 2'b01 ? bus.rs_val :
                  bus.loSel == 2'b10 ? mac_d[WIDTH-1:0] : lo_q;
        // res/MAC sources are stale while the engine runs; rs_val moves are always safe
        hi_blk  = busy_q & ~bus.hiSel[0];
        lo_blk  = busy_q & ~bus.loSel[0];
        hi_we   = bus.hiWr & ~hi_blk;
        lo_we   = bus.loWr & ~lo_blk;
        prod    = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        rem_sh  = {rem_q, a_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, b_q};
        quo_fix = (sa_q ^ sb_q) ? -a_q : a_q;
        rem_fix = sa_q ? -rem_q : rem_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            res_q    <= '0;
            hi_q     <= HILO_RESET;
            lo_q     <= HILO_RESET;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hazard_q <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            dz_q     <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            hazard_q <= (bus.hiWr & hi_blk) | (bus.loWr & lo_blk);
`ifdef DIV_ZERO_TRAP_EN
            dbz_q    <= 1'b0;
`endif
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
            case (state_q)
                IDLE: begin
                    if (bus.start_div) begin
                        state_q <= DIV;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        a_q     <= bus.rs_val[WIDTH-1] ? -bus.rs_val : bus.rs_val;
                        b_q     <= bus.rt_val[WIDTH-1] ? -bus.rt_val : bus.rt_val;
                        sa_q    <= bus.rs_val[WIDTH-1];
                        sb_q    <= bus.rt_val[WIDTH-1];
`ifdef DIV_ZERO_TRAP_EN
                        dz_q    <= bus.rt_val == '0;
                        rem_q   <= bus.rt_val == '0 ? bus.rs_val : '0;
`else
                        rem_q   <= '0;
`endif
                    end else if (bus.start_mul) begin
                        state_q <= MUL;
                        busy_q  <= 1'b1;
                        a_q     <= bus.rs_val;
                        b_q     <= bus.rt_val;
                    end
                end
                MUL: begin
                    res_q   <= prod;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DIV: begin
`ifdef DIV_ZERO_TRAP_EN
                    if (dz_q) begin
                        res_q   <= {rem_q, {WIDTH{1'b1}}};
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b1;
                    end else
`endif
                    if (cnt_q == LAST) begin
                        res_q   <= {rem_fix, quo_fix};
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        rem_q <= rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
                        a_q   <= {a_q[WIDTH-2:0], ~rem_sub[WIDTH]};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.hazard = hazard_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed HI/LO mul/div vectors checked by a queue-based scoreboard.
module tb_hilo_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    hilo_muldiv_if #(.WIDTH(32)) ifc();
    hilo_muldiv_unit #(.WIDTH(32), .HILO_RESET(32'h0)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
`ifdef DIV_ZERO_TRAP_EN
    localparam int   ZLAT = 1;
    localparam logic ZDZ  = 1'b1;
`else
    localparam int   ZLAT = 33;
    localparam logic ZDZ  = 1'b0;
`endif
    typedef struct {int lat; logic dz;} done_t;
    typedef struct {logic [31:0] hi; logic [31:0] lo; logic hz;} wr_t;
    done_t dq[$];
    wr_t   wq[$];
    done_t de;
    wr_t   we;
    int    errors = 0, checks = 0, cyc = 0, st = 0;
    logic  wr_seen;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic sm, input logic sd, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [1:0] hs, input logic [1:0] ls, input logic hw, input logic lw, input logic mop);
        ifc.start_mul = sm; ifc.start_div = sd; ifc.rs_val = rs; ifc.rt_val = rt;
        ifc.hiSel = hs; ifc.loSel = ls; ifc.hiWr = hw; ifc.loWr = lw; ifc.mALUOp = mop;
        @(negedge clk);
        ifc.start_mul = 1'b0; ifc.start_div = 1'b0; ifc.rs_val = '0; ifc.rt_val = '0;
        ifc.hiSel = 2'b11; ifc.loSel = 2'b11; ifc.hiWr = 1'b0; ifc.loWr = 1'b0; ifc.mALUOp = 1'b0;
    endtask
    task automatic op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b, input int lat, input logic dz);
        dq.push_back('{lat, dz});
        drive(sm, sd, a, b, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic wr(input logic [1:0] hs, input logic [1:0] ls, input logic [31:0] rs, input logic mop,
                      input logic [31:0] ehi, input logic [31:0] elo, input logic ehz);
        wq.push_back('{ehi, elo, ehz});
        drive(1'b0, 1'b0, rs, 32'h0, hs, ls, 1'b1, 1'b1, mop);
    endtask
    task automatic wait_done();
        int n = 0;
        while (!ifc.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles", n);
        end
    endtask
    // monitor: latency is counted from the edge that accepted the start to the edge that raised done
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            wr_seen = ifc.hiWr | ifc.loWr;
            if ((ifc.start_mul | ifc.start_div) && !ifc.busy && !rst) st = cyc;
            @(negedge clk);
            if (ifc.done) begin
                if (dq.size() == 0) chk("unexpected_done", 64'(dq.size()), 64'd1);
                else begin
                    de = dq.pop_front();
                    chk("done_latency", 64'(cyc - st), 64'(de.lat));
                    chk("div_by_zero", 64'(ifc.div_by_zero), 64'(de.dz));
                end
            end
            if (wr_seen && !rst) begin
                if (wq.size() == 0) chk("unexpected_write", 64'(wq.size()), 64'd1);
                else begin
                    we = wq.pop_front();
                    chk("hi", 64'(ifc.hi), 64'(we.hi));
                    chk("lo", 64'(ifc.lo), 64'(we.lo));
                    chk("hazard", 64'(ifc.hazard), 64'(we.hz));
                end
            end
        end
    end
    initial begin
        ifc.start_mul = 1'b0; ifc.start_div = 1'b0; ifc.rs_val = '0; ifc.rt_val = '0;
        ifc.hiSel = 2'b11; ifc.loSel = 2'b11; ifc.hiWr = 1'b0; ifc.loWr = 1'b0; ifc.mALUOp = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_hi", 64'(ifc.hi), 64'h0);
        chk("rst_lo", 64'(ifc.lo), 64'h0);
        chk("rst_busy", 64'(ifc.busy), 64'h0);
        chk("rst_done", 64'(ifc.done), 64'h0);
        chk("rst_hazard", 64'(ifc.hazard), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op(1'b1, 1'b0, 32'hFFFFFFFD, 32'd7, 1, 1'b0);
        wait_done();
        wr(2'b00, 2'b00, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        op(1'b0, 1'b1, 32'hFFFFFFEF, 32'd5, 33, 1'b0);
        chk("div_busy", 64'(ifc.busy), 64'h1);
        wait_done();
        wr(2'b00, 2'b00, 32'h0, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        wq.push_back('{32'h0, 32'hFFFFFFFD, 1'b0});
        drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
        wq.push_back('{32'h0, 32'd10, 1'b0});
        drive(1'b0, 1'b0, 32'd10, 32'h0, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 32'd3, 32'd4, 1, 1'b0);
        wait_done();
        wr(2'b10, 2'b10, 32'h0, 1'b0, 32'h0, 32'd22, 1'b0);
        op(1'b1, 1'b0, 32'd5, 32'd6, 1, 1'b0);
        wait_done();
        wr(2'b10, 2'b10, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b0);
        op(1'b0, 1'b1, 32'd100, 32'd7, 33, 1'b0);
        repeat (9) @(negedge clk);
        wq.push_back('{32'h0000ABCD, 32'hFFFFFFF8, 1'b1});
        drive(1'b0, 1'b0, 32'h0000ABCD, 32'h0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        wait_done();
        wr(2'b00, 2'b00, 32'h0, 1'b0, 32'd2, 32'd14, 1'b0);
        op(1'b1, 1'b1, 32'd20, 32'd3, 33, 1'b0);
        wait_done();
        wr(2'b00, 2'b00, 32'h0, 1'b0, 32'd2, 32'd6, 1'b0);
        op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0);
        wait_done();
        wr(2'b00, 2'b00, 32'h0, 1'b0, 32'h0, 32'h80000000, 1'b0);
        drive(1'b0, 1'b1, 32'd1, 32'd1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(ifc.busy), 64'h0);
        chk("abort_hi", 64'(ifc.hi), 64'h0);
        chk("abort_lo", 64'(ifc.lo), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op(1'b1, 1'b0, 32'd2, 32'd2, 1, 1'b0);
        wait_done();
        wr(2'b00, 2'b00, 32'h0, 1'b0, 32'h0, 32'd4, 1'b0);
        op(1'b0, 1'b1, 32'd100, 32'd0, ZLAT, ZDZ);
        wait_done();
        wr(2'b00, 2'b00, 32'h0, 1'b0, 32'd100, 32'hFFFFFFFF, 1'b0);
        repeat (3) @(negedge clk);
        chk("done_queue_empty", 64'(dq.size()), 64'h0);
        chk("write_queue_empty", 64'(wq.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
